// File: rtl/jtdsp16_do_loop.sv
// Do-loop sequencer: turns do/redo execution into cached-body replay offsets and iteration counts.
// Optional feature macro: JTDSP16_DO_REDO_EN keeps the loop shape so a later redo can replay it.
module jtdsp16_do_loop (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        do_en,
    input  logic        redo_en,
    input  logic        stall,
    input  logic [10:0] i_field,
    output logic        do_start,
    output logic        do_redo,
    output logic        do_save,
    output logic        do_short,
    output logic        do_out,
    output logic [3:0]  do_pc,
    output logic [10:0] do_data,
    output logic        do_busy,
    output logic [6:0]  debug_k
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_reg;
    logic [3:0] ni_reg;
    logic [6:0] kf_reg;
    logic [6:0] k_reg;
    logic [3:0] pc_reg;

    logic [3:0] field_ni;
    logic [6:0] field_k;
    logic [6:0] k_init;
    logic       do_ok;
    logic       redo_ok;
    logic       idle_go;
    logic       last_pos;

    assign field_ni = i_field[10:7];
    assign field_k  = i_field[6:0];
    // K of 0 still runs the body once
    assign k_init   = (field_k == 7'd0) ? 7'd1 : field_k;

    assign do_ok    = do_en && (field_ni != 4'd0);

`ifdef JTDSP16_DO_REDO_EN
    // do_en has priority, even when its NI would reject the entry
    assign redo_ok  = redo_en && !do_en && (ni_reg != 4'd0);
`else
    logic unused_redo;
    assign unused_redo = redo_en;
    assign redo_ok     = 1'b0;
`endif

    assign idle_go  = (state_reg == IDLE) && !stall;
    assign last_pos = (pc_reg == ni_reg - 4'd1);

    assign do_start = idle_go && (do_ok || redo_ok);
    assign do_save  = idle_go && do_ok;
    assign do_redo  = idle_go && redo_ok;
    assign do_out   = (state_reg == RUN) && last_pos && (k_reg == 7'd1) && !stall;

    assign do_short = (ni_reg == 4'd1);
    assign do_pc    = pc_reg;
    assign do_data  = {ni_reg, kf_reg};
    assign do_busy  = (state_reg == RUN);
    assign debug_k  = k_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ni_reg    <= 4'd0;
            kf_reg    <= 7'd0;
            k_reg     <= 7'd0;
            pc_reg    <= 4'd0;
        end else if (cen) begin
            case (state_reg)
                IDLE: begin
                    if (do_start) begin
                        state_reg <= RUN;
                        pc_reg    <= 4'd0;
                        k_reg     <= k_init;
                        kf_reg    <= field_k;
                        if (do_save) ni_reg <= field_ni;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (!last_pos) begin
                            pc_reg <= pc_reg + 4'd1;
                        end else if (k_reg > 7'd1) begin
                            pc_reg <= 4'd0;
                            k_reg  <= k_reg - 7'd1;
                        end else begin
                            state_reg <= IDLE;
                            pc_reg    <= 4'd0;
                            k_reg     <= 7'd0;
`ifndef JTDSP16_DO_REDO_EN
                            ni_reg    <= 4'd0;
`endif
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtdsp16_do_loop.sv
// Bench for jtdsp16_do_loop: elapsed-cycle loop model checked every cycle, plus directed literal pins.
module tb_jtdsp16_do_loop;

`ifdef JTDSP16_DO_REDO_EN
    localparam bit REDO = 1'b1;
`else
    localparam bit REDO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        do_en = 1'b0;
    logic        redo_en = 1'b0;
    logic        stall = 1'b0;
    logic [10:0] i_field = 11'd0;
    logic        do_start, do_redo, do_save, do_short, do_out, do_busy;
    logic [3:0]  do_pc;
    logic [10:0] do_data;
    logic [6:0]  debug_k;

    int n_checks = 0;
    int n_fail   = 0;

    jtdsp16_do_loop dut (
        .clk(clk), .rst(rst), .cen(cen), .do_en(do_en), .redo_en(redo_en),
        .stall(stall), .i_field(i_field), .do_start(do_start), .do_redo(do_redo),
        .do_save(do_save), .do_short(do_short), .do_out(do_out), .do_pc(do_pc),
        .do_data(do_data), .do_busy(do_busy), .debug_k(debug_k)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a loop is NI*max(K,1) non-stalled cycles; position is derived from the elapsed count.
    bit m_busy = 0;
    int m_ni = 0, m_kf = 0, m_kmax = 0, m_e = 0;

    function automatic bit m_do_ok();
        return do_en && (i_field[10:7] != 0);
    endfunction
    function automatic bit m_redo_ok();
        return REDO && redo_en && !do_en && (m_ni != 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_ni = 0; m_kf = 0; m_kmax = 0; m_e = 0;
        end else if (cen) begin
            if (!m_busy) begin
                if (!stall && (m_do_ok() || m_redo_ok())) begin
                    if (m_do_ok()) m_ni = int'(i_field[10:7]);
                    m_kf   = int'(i_field[6:0]);
                    m_kmax = (m_kf == 0) ? 1 : m_kf;
                    m_e    = 0;
                    m_busy = 1;
                end
            end else if (!stall) begin
                if (m_e == m_ni * m_kmax - 1) begin
                    m_busy = 0;
                    if (!REDO) m_ni = 0;
                end else begin
                    m_e++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", int'(do_busy), 0);
            chk("rst_pc", int'(do_pc), 0);
            chk("rst_k", int'(debug_k), 0);
            chk("rst_data", int'(do_data), 0);
        end else begin
            chk("busy", int'(do_busy), int'(m_busy));
            chk("pc", int'(do_pc), m_busy ? (m_e % m_ni) : 0);
            chk("k", int'(debug_k), m_busy ? (m_kmax - m_e / m_ni) : 0);
            chk("data", int'(do_data), (m_ni << 7) | m_kf);
            chk("short", int'(do_short), int'(m_ni == 1));
            if (cen) begin
                chk("start", int'(do_start),
                    int'(!m_busy && !stall && (m_do_ok() || m_redo_ok())));
                chk("save", int'(do_save), int'(!m_busy && !stall && m_do_ok()));
                chk("redo", int'(do_redo), int'(!m_busy && !stall && m_redo_ok()));
                chk("out", int'(do_out),
                    int'(m_busy && !stall && (m_e == m_ni * m_kmax - 1)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit d, input bit r, input bit s, input int ni, input int k);
        do_en = d; redo_en = r; stall = s;
        i_field = {ni[3:0], k[6:0]};
    endtask

    // Count RUN cycles until the loop exits, bounded.
    task automatic run_out(output int cycles);
        cycles = 0;
        while (do_busy && cycles < 3000) begin
            cycles++;
            tick();
        end
        if (cycles >= 3000) chk("timeout", cycles, -1);
    endtask

    int cyc;
    int lit_pc[6] = '{0, 1, 0, 1, 0, 1};
    int lit_k[6]  = '{3, 3, 2, 2, 1, 1};

    initial begin
        repeat (2) tick();
        chk("reset_busy", int'(do_busy), 0);
        chk("reset_start", int'(do_start), 0);
        rst = 1'b0;
        tick();

        // NI=2 K=3
        set_in(1, 0, 0, 2, 3); #1;
        chk("t1_start", int'(do_start), 1);
        chk("t1_save", int'(do_save), 1);
        tick();
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            chk("t1_busy", int'(do_busy), 1);
            chk("t1_pc", int'(do_pc), lit_pc[i]);
            chk("t1_k", int'(debug_k), lit_k[i]);
            chk("t1_out", int'(do_out), int'(i == 5));
            tick();
        end
        chk("t1_exit", int'(do_busy), 0);
        $display("txn do NI=2 K=3");

        // NI=4 K=0 single pass, then NI=0 rejected
        set_in(1, 0, 0, 4, 0); tick(); set_in(0, 0, 0, 0, 0);
        run_out(cyc);
        chk("t2_cycles", cyc, 4);
        set_in(1, 0, 0, 0, 5); #1;
        chk("t2_ni0_start", int'(do_start), 0);
        tick(); set_in(0, 0, 0, 0, 0);
        chk("t2_ni0_busy", int'(do_busy), 0);
        $display("txn do NI=4 K=0 then NI=0");

        // NI=3 K=2, then redo K=2
        set_in(1, 0, 0, 3, 2); tick(); set_in(0, 0, 0, 0, 0);
        run_out(cyc);
        chk("t3_cycles", cyc, 6);
        set_in(0, 1, 0, 0, 2); #1;
        if (REDO) begin
            chk("t3_redo", int'(do_redo), 1);
            chk("t3_redo_save", int'(do_save), 0);
            tick(); set_in(0, 0, 0, 0, 0);
            chk("t3_redo_ni", int'(do_data[10:7]), 3);
            run_out(cyc);
            chk("t3_redo_cycles", cyc, 6);
        end else begin
            chk("t3_noredo_start", int'(do_start), 0);
            tick(); set_in(0, 0, 0, 0, 0);
            chk("t3_noredo_busy", int'(do_busy), 0);
        end
        $display("txn do NI=3 K=2 then redo");

        // NI=1 K=4 with a 2-cycle stall
        set_in(1, 0, 0, 1, 4); tick(); set_in(0, 0, 0, 0, 0);
        chk("t4_short", int'(do_short), 1);
        tick();
        stall = 1'b1; #1;
        chk("t4_stall_out", int'(do_out), 0);
        tick(); tick();
        stall = 1'b0;
        run_out(cyc);
        chk("t4_cycles", cyc + 3, 6);
        $display("txn do NI=1 K=4 stalled");

        // Async reset during iteration 2 of NI=2 K=5
        set_in(1, 0, 0, 2, 5); tick(); set_in(0, 0, 0, 0, 0);
        tick(); tick();
        chk("t5_pre_k", int'(debug_k), 4);
        #1 rst = 1'b1; #1;
        chk("t5_rst_busy", int'(do_busy), 0);
        chk("t5_rst_pc", int'(do_pc), 0);
        chk("t5_rst_k", int'(debug_k), 0);
        tick(); rst = 1'b0; tick();
        set_in(0, 1, 0, 0, 3); #1;
        chk("t5_redo_after_rst", int'(do_start), 0);
        tick(); set_in(0, 0, 0, 0, 0);
        $display("txn reset mid-loop");

        // do+redo together, then do_en during RUN
        set_in(1, 1, 0, 2, 2); #1;
        chk("t6_both_save", int'(do_save), 1);
        chk("t6_both_redo", int'(do_redo), 0);
        tick();
        set_in(1, 1, 0, 5, 7);
        run_out(cyc);
        set_in(0, 0, 0, 0, 0);
        chk("t6_cycles", cyc, 4);
        tick();
        $display("txn do+redo then do in RUN");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cen     = ($urandom_range(0, 9) != 0);
            do_en   = ($urandom_range(0, 5) == 0);
            redo_en = ($urandom_range(0, 4) == 0);
            stall   = ($urandom_range(0, 7) == 0);
            i_field = {4'($urandom_range(0, 5)), 7'($urandom_range(0, 6))};
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0); cen = 1'b1;
        tick();
        $display("txn random traffic done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
